// File: rtl/digit_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package digit_serial_pkg;

  // FSM state encoding, kept as plain constants for legacy tool flows
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Number of digits in an N-bit operand
  function automatic int unsigned ndig(input int unsigned n, input int unsigned d);
    return (d == 0) ? 0 : n / d;
  endfunction

  // Digit counter width; at least one bit so the register always exists
  function automatic int unsigned cntw(input int unsigned n, input int unsigned d);
    int unsigned nd;
    nd = ndig(n, d);
    return (nd <= 2) ? 1 : int'($clog2(nd));
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for the digit-serial adder.
interface digit_serial_adder_if #(
  parameter int unsigned N = 16
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] z;
  logic         cout;
  logic         ovf;

  // Producer/consumer side
  modport master (
    output in_valid, x, y, cin, sub, out_ready,
    input  in_ready, out_valid, z, cout, ovf
  );

  // Adder side
  modport slave (
    input  in_valid, x, y, cin, sub, out_ready,
    output in_ready, out_valid, z, cout, ovf
  );

endinterface

// File: rtl/digit_adder.sv
// Combinational D-bit ripple adder built from 1-bit full-adder cells.
module digit_adder #(
  parameter int unsigned D = 4
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         ci,
  output logic [D-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic carry;

  // Ripple one full-adder cell per bit; carry into the top bit recovered from its sum
  always_comb begin
    carry = ci;
    s     = '0;
    for (int i = 0; i < int'(D); i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co    = carry;
    c_msb = s[D-1] ^ a[D-1] ^ b[D-1];
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle N-bit adder/subtractor processing D bits per clock, LSB digit first.
module digit_serial_adder
  import digit_serial_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned D      = 4,
  parameter int unsigned SUB_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  digit_serial_adder_if.slave     bus
);

  localparam int unsigned NDIG = ndig(N, D);
  localparam int unsigned CNTW = cntw(N, D);
  localparam logic [CNTW-1:0] LAST_DIG = CNTW'(NDIG - 1);
  localparam logic [N-1:0]    DIG_MASK = N'({D{1'b1}});

  // Reject geometries where the operand does not split into whole digits
  if ((D < 1) || (D > N) || ((N % D) != 0)) begin : g_param_err
    $error("digit_serial_adder: N must be a multiple of D with 1 <= D <= N");
  end

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    x_q, x_d;
  logic [N-1:0]    y_q, y_d;
  logic            sub_q, sub_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    z_q, z_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            out_valid_q, out_valid_d;

  logic            sub_in;
  logic [D-1:0]    dig_sum;
  logic            dig_co;
  logic            dig_c_msb;
  logic [31:0]     dig_sh;

  // Subtract request is ignored entirely in add-only builds
  assign sub_in = (SUB_EN != 0) ? bus.sub : 1'b0;

  // Bit offset of the digit being written this cycle
  assign dig_sh = 32'(cnt_q) * 32'(D);

  // Operand registers shift right each digit so the current digit is always at the bottom
  digit_adder #(.D(D)) u_digit_adder (
    .a     (x_q[D-1:0]),
    .b     (y_q[D-1:0]),
    .ci    (carry_q),
    .s     (dig_sum),
    .co    (dig_co),
    .c_msb (dig_c_msb)
  );

  // Next-state, datapath and result assembly
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    z_d         = z_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_RUN;
          x_d     = bus.x;
          y_d     = bus.y ^ {N{sub_in}};
          sub_d   = sub_in;
          carry_d = sub_in ? ~bus.cin : bus.cin;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        z_d     = (z_q & ~(DIG_MASK << dig_sh)) | (N'(dig_sum) << dig_sh);
        carry_d = dig_co;
        x_d     = x_q >> D;
        y_d     = y_q >> D;
        if (cnt_q == LAST_DIG) begin
          state_d     = ST_DONE;
          cout_d      = dig_co ^ sub_q;
          ovf_d       = dig_c_msb ^ dig_co;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, operand, carry and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      z_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      z_q         <= z_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: D=4 main instance plus D=1 and D=16 builds.
module tb_digit_serial_adder;

  localparam int unsigned N = 16;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic        sub;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  digit_serial_adder_if #(.N(N)) ifa ();
  digit_serial_adder_if #(.N(N)) ifb ();
  digit_serial_adder_if #(.N(N)) ifc ();

  digit_serial_adder #(.N(N), .D(4),  .SUB_EN(1)) u_d4  (.clk(clk), .rst_n(rst_n), .bus(ifa));
  digit_serial_adder #(.N(N), .D(1),  .SUB_EN(1)) u_d1  (.clk(clk), .rst_n(rst_n), .bus(ifb));
  digit_serial_adder #(.N(N), .D(16), .SUB_EN(1)) u_d16 (.clk(clk), .rst_n(rst_n), .bus(ifc));

  // Reference: plain integer arithmetic; returns {cout, ovf, z}
  function automatic logic [17:0] ref_model(input vec_t v);
    longint ux, uy, sx, sy, r, s;
    logic [15:0] zz;
    logic co, ov;
    ux = longint'(v.x);
    uy = longint'(v.y);
    sx = longint'($signed(v.x));
    sy = longint'($signed(v.y));
    if (v.sub) begin
      r  = ux - uy - longint'(v.cin);
      s  = sx - sy - longint'(v.cin);
      co = (r < 0);
    end else begin
      r  = ux + uy + longint'(v.cin);
      s  = sx + sy + longint'(v.cin);
      co = (r > 65535);
    end
    zz = r[15:0];
    ov = (s > 32767) || (s < -32768);
    return {co, ov, zz};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.x   = 16'($urandom);
    v.y   = 16'($urandom);
    v.cin = 1'($urandom);
    v.sub = 1'($urandom);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input vec_t v);
    ifa.x   = v.x;
    ifa.y   = v.y;
    ifa.cin = v.cin;
    ifa.sub = v.sub;
  endtask

  // Present an operation to the D=4 instance and return just after its accept edge
  task automatic start_op(input vec_t v);
    int g = 0;
    while (!ifa.in_ready && g < 20) begin
      tick();
      g++;
    end
    if (!ifa.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL start_op timeout: in_ready=%b required 1", ifa.in_ready);
    end
    drive_a(v);
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
  endtask

  // Count edges from accept until out_valid, then capture the result
  task automatic wait_result(output logic [15:0] z, output logic co, output logic ov, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!ifa.out_valid && lat < 40);
    if (!ifa.out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_result timeout: out_valid=%b required 1", ifa.out_valid);
    end
    z  = ifa.z;
    co = ifa.cout;
    ov = ifa.ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", ifa.out_valid); end
    n_cmp++; if (ifa.z !== 16'h0000) begin n_bad++; $display("FAIL reset z: got %h want 0000", ifa.z); end
    n_cmp++; if (ifa.cout !== 1'b0) begin n_bad++; $display("FAIL reset cout: got %b want 0", ifa.cout); end
    n_cmp++; if (ifa.ovf !== 1'b0) begin n_bad++; $display("FAIL reset ovf: got %b want 0", ifa.ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", ifa.in_ready); end
  endtask

  // Directed add and subtract vectors, including carry/borrow and overflow corners
  task automatic test_add_sub();
    vec_t v[6];
    logic [17:0] e;
    logic [15:0] z;
    logic co, ov;
    int lat;
    v[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0};
    v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0};
    v[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0};
    v[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1};
    v[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1};
    v[5] = '{16'h0003, 16'h0001, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      start_op(v[i]);
      wait_result(z, co, ov, lat);
      e = ref_model(v[i]);
      n_cmp++; if (z !== e[15:0]) begin n_bad++; $display("FAIL dir%0d z: got %h want %h", i, z, e[15:0]); end
      n_cmp++; if (co !== e[17]) begin n_bad++; $display("FAIL dir%0d cout: got %b want %b", i, co, e[17]); end
      n_cmp++; if (ov !== e[16]) begin n_bad++; $display("FAIL dir%0d ovf: got %b want %b", i, ov, e[16]); end
      n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL dir%0d latency: got %0d want 4", i, lat); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    vec_t v, junk;
    logic [17:0] e;
    logic [15:0] z;
    logic co, ov;
    int lat;
    v = rand_vec();
    ifa.out_ready = 1'b0;
    start_op(v);
    wait_result(z, co, ov, lat);
    e = ref_model(v);
    n_cmp++; if ({co, ov, z} !== e) begin n_bad++; $display("FAIL bp result: got %h want %h", {co, ov, z}, e); end
    for (int i = 0; i < 3; i++) begin
      junk = rand_vec();
      drive_a(junk);
      ifa.in_valid = 1'(i != 1);
      tick();
      n_cmp++; if (ifa.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp%0d out_valid: got %b want 1", i, ifa.out_valid); end
      n_cmp++; if ({ifa.cout, ifa.ovf, ifa.z} !== e) begin n_bad++; $display("FAIL bp%0d hold: got %h want %h", i, {ifa.cout, ifa.ovf, ifa.z}, e); end
      n_cmp++; if (ifa.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp%0d in_ready: got %b want 0", i, ifa.in_ready); end
    end
    ifa.in_valid  = 1'b1;
    ifa.out_ready = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp release out_valid: got %b want 0", ifa.out_valid); end
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp release in_ready: got %b want 1", ifa.in_ready); end
    tick();
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp no-accept in_ready: got %b want 1", ifa.in_ready); end
    n_cmp++; if ({ifa.cout, ifa.ovf, ifa.z} !== e) begin n_bad++; $display("FAIL bp idle hold: got %h want %h", {ifa.cout, ifa.ovf, ifa.z}, e); end
  endtask

  // in_valid held high with operands scrambled every cycle
  task automatic test_back_to_back();
    logic [17:0] exp_q[$];
    int acc[$];
    int n_acc = 0;
    vec_t v;
    logic [17:0] e;
    for (int cyc = 0; cyc < 60; cyc++) begin
      v = rand_vec();
      drive_a(v);
      ifa.in_valid = (n_acc < 4);
      if (ifa.in_valid && ifa.in_ready) begin
        exp_q.push_back(ref_model(v));
        acc.push_back(cyc);
        n_acc++;
      end
      tick();
      if (ifa.out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL b2b unexpected out_valid at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({ifa.cout, ifa.ovf, ifa.z} !== e) begin
            n_bad++;
            $display("FAIL b2b result: got %h want %h", {ifa.cout, ifa.ovf, ifa.z}, e);
          end
        end
      end
    end
    ifa.in_valid = 1'b0;
    n_cmp++;
    if (n_acc != 4 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b count: accepted %0d pending %0d want 4 and 0", n_acc, exp_q.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      n_cmp++;
      if (acc[i] - acc[i-1] != 6) begin
        n_bad++;
        $display("FAIL b2b spacing%0d: got %0d want 6", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    vec_t v;
    logic [17:0] e;
    logic [15:0] z;
    logic co, ov;
    int lat;
    v = '{16'h1234, 16'h4321, 1'b0, 1'b0};
    start_op(v);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ifa.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst out_valid: got %b want 0", ifa.out_valid); end
    n_cmp++; if (ifa.z !== 16'h0000) begin n_bad++; $display("FAIL midrst z: got %h want 0000", ifa.z); end
    n_cmp++; if ({ifa.cout, ifa.ovf} !== 2'b00) begin n_bad++; $display("FAIL midrst cout/ovf: got %b want 00", {ifa.cout, ifa.ovf}); end
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst in_ready: got %b want 1", ifa.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_op(v);
    wait_result(z, co, ov, lat);
    e = ref_model(v);
    n_cmp++; if ({co, ov, z} !== e) begin n_bad++; $display("FAIL midrst rerun: got %h want %h", {co, ov, z}, e); end
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL midrst latency: got %0d want 4", lat); end
    tick();
  endtask

  task automatic test_random();
    vec_t v;
    logic [17:0] e;
    logic [15:0] z;
    logic co, ov;
    int lat;
    for (int i = 0; i < 40; i++) begin
      v = rand_vec();
      start_op(v);
      wait_result(z, co, ov, lat);
      e = ref_model(v);
      n_cmp++;
      if ({co, ov, z} !== e) begin
        n_bad++;
        $display("FAIL rand%0d x=%h y=%h cin=%b sub=%b: got %h want %h", i, v.x, v.y, v.cin, v.sub, {co, ov, z}, e);
      end
      tick();
    end
  endtask

  // D=1 and D=16 builds run the same random operations side by side
  task automatic test_widths();
    vec_t v;
    logic [17:0] e, rb, rc;
    int lb, lc;
    for (int i = 0; i < 8; i++) begin
      v = rand_vec();
      e = ref_model(v);
      lb = 0;
      lc = 0;
      rb = '0;
      rc = '0;
      ifb.x = v.x; ifb.y = v.y; ifb.cin = v.cin; ifb.sub = v.sub;
      ifc.x = v.x; ifc.y = v.y; ifc.cin = v.cin; ifc.sub = v.sub;
      ifb.in_valid = 1'b1;
      ifc.in_valid = 1'b1;
      tick();
      ifb.in_valid = 1'b0;
      ifc.in_valid = 1'b0;
      for (int t = 1; t <= 20; t++) begin
        tick();
        if (ifb.out_valid && lb == 0) begin lb = t; rb = {ifb.cout, ifb.ovf, ifb.z}; end
        if (ifc.out_valid && lc == 0) begin lc = t; rc = {ifc.cout, ifc.ovf, ifc.z}; end
      end
      n_cmp++; if (lb != 16) begin n_bad++; $display("FAIL d1_%0d latency: got %0d want 16", i, lb); end
      n_cmp++; if (rb !== e) begin n_bad++; $display("FAIL d1_%0d result: got %h want %h", i, rb, e); end
      n_cmp++; if (lc != 1) begin n_bad++; $display("FAIL d16_%0d latency: got %0d want 1", i, lc); end
      n_cmp++; if (rc !== e) begin n_bad++; $display("FAIL d16_%0d result: got %h want %h", i, rc, e); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.x = '0; ifa.y = '0; ifa.cin = 1'b0; ifa.sub = 1'b0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.x = '0; ifb.y = '0; ifb.cin = 1'b0; ifb.sub = 1'b0; ifb.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.x = '0; ifc.y = '0; ifc.cin = 1'b0; ifc.sub = 1'b0; ifc.out_ready = 1'b1;
    test_reset();
    test_add_sub();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    test_widths();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
